// File: rtl/fifo_slave_pkg.sv
// Shared definitions for the CPLD-as-FIFO-slave flow controller and its helpers.
package fifo_slave_pkg;

    // Controller states: waiting for run, presenting source words,
    // accepting sink words, and the quiet period between bursts.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SRC_ACTIVE = 2'd1,
        SNK_ACTIVE = 2'd2,
        GAP        = 2'd3
    } state_t;

    // Direction encoding of the Mode input.
    localparam logic MODE_SOURCE = 1'b0;
    localparam logic MODE_SINK   = 1'b1;

    // Width of the host data bus handled by the counter/data block.
    localparam int DQ_WIDTH = 32;

    // Bits needed for a counter that runs 0 .. n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_slave_debounce.sv
// Push-button conditioner: two-flop synchroniser followed by a stability
// filter. The filtered level only changes after the synchronised input has
// held a new value for STABLE_CYCLES consecutive clocks; rise pulses for one
// cycle when the filtered level goes 0 -> 1.
module fifo_slave_debounce
    import fifo_slave_pkg::*;
#(
    parameter int STABLE_CYCLES = 65536
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic rise
);

    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] stable_cnt;
    logic          accept;

    // The candidate level is accepted on the cycle that completes the run of
    // STABLE_CYCLES consecutive samples differing from the current level.
    assign accept = (sync_b != level) && (stable_cnt == CNT_LAST);

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= button;
            sync_b <= sync_a;
        end
    end

    // Count how long the synchronised input has disagreed with the filtered
    // level; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_cnt <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
        end else begin
            rise <= accept & sync_b;
            if (sync_b == level) begin
                stable_cnt <= '0;
            end else if (accept) begin
                level      <= sync_b;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_slave_flow_ctrl.sv
// Burst flow controller for the CPLD-as-FIFO-slave datapath. Presents the
// emulated FIFO flags to the host, turns host strobes into advance/capture
// pulses for the data source and sink, sequences bursts separated by quiet
// gaps, and flags host protocol violations.
module fifo_slave_flow_ctrl
    import fifo_slave_pkg::*;
#(
    parameter int BURST_WORDS     = 1024,
    parameter int GAP_CYCLES      = 16,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic       PCLK,
    input  logic       RESET,
    input  logic       WR_n,
    input  logic       RD_n,
    input  logic       OE_n,
    input  logic       PushButton,
    input  logic       Mode,
    output logic       WR_FIFO_Full,
    output logic       RD_FIFO_Empty,
    output logic       LastRDData,
    output logic       src_advance,
    output logic       snk_capture,
    output logic       dq_oe,
    output logic       run,
    output logic [7:0] burst_count,
    output logic       proto_err
);

    localparam int WC_W = cnt_width(BURST_WORDS);
    localparam int GC_W = cnt_width(GAP_CYCLES);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(BURST_WORDS - 1);
    localparam logic [GC_W-1:0] GAP_LAST  = GC_W'(GAP_CYCLES - 1);

    state_t          state;
    state_t          state_next;
    logic [WC_W-1:0] word_cnt;
    logic [WC_W-1:0] word_cnt_next;
    logic [GC_W-1:0] gap_cnt;
    logic [GC_W-1:0] gap_cnt_next;

    logic run_req;
    logic btn_level;
    logic btn_rise;

    logic rd_strobe;
    logic wr_strobe;
    logic oe_active;
    logic read_ok;
    logic write_ok;
    logic strobe_err;
    logic burst_done;
    logic leaving_idle;

    fifo_slave_debounce #(
        .STABLE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button (
        .clk   (PCLK),
        .reset (RESET),
        .button(PushButton),
        .level (btn_level),
        .rise  (btn_rise)
    );

    assign rd_strobe = ~RD_n;
    assign wr_strobe = ~WR_n;
    assign oe_active = ~OE_n;

    // A strobe is honoured only in its own active state and never when both
    // strobes collide; anything else is a protocol violation.
    assign read_ok    = rd_strobe & oe_active & ~wr_strobe & (state == SRC_ACTIVE);
    assign write_ok   = wr_strobe & ~rd_strobe & (state == SNK_ACTIVE);
    assign strobe_err = (rd_strobe & (state != SRC_ACTIVE))
                      | (wr_strobe & (state != SNK_ACTIVE))
                      | (rd_strobe & wr_strobe);

    assign dq_oe = oe_active & (state == SRC_ACTIVE);

    // While idle the LED follows the run request; once a burst has started it
    // stays lit until the controller is back in IDLE.
    assign run = (state == IDLE) ? run_req : 1'b1;

    // Next-state logic: burst sequencing, word and gap counting, strobe pulses.
    always_comb begin
        state_next    = state;
        word_cnt_next = word_cnt;
        gap_cnt_next  = gap_cnt;
        burst_done    = 1'b0;
        leaving_idle  = 1'b0;
        src_advance   = 1'b0;
        snk_capture   = 1'b0;

        case (state)
            IDLE: begin
                word_cnt_next = '0;
                gap_cnt_next  = '0;
                if (run_req) begin
                    leaving_idle = 1'b1;
                    state_next   = (Mode == MODE_SINK) ? SNK_ACTIVE : SRC_ACTIVE;
                end
            end

            SRC_ACTIVE: begin
                if (read_ok) begin
                    src_advance = 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        burst_done    = 1'b1;
                        word_cnt_next = '0;
                        gap_cnt_next  = '0;
                        state_next    = GAP;
                    end else begin
                        word_cnt_next = word_cnt + WC_W'(1);
                    end
                end
            end

            SNK_ACTIVE: begin
                if (write_ok) begin
                    snk_capture = 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        burst_done    = 1'b1;
                        word_cnt_next = '0;
                        gap_cnt_next  = '0;
                        state_next    = GAP;
                    end else begin
                        word_cnt_next = word_cnt + WC_W'(1);
                    end
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_next = '0;
                    if (run_req) begin
                        state_next = (Mode == MODE_SINK) ? SNK_ACTIVE : SRC_ACTIVE;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt + GC_W'(1);
                end
            end

            default: begin
                state_next    = IDLE;
                word_cnt_next = '0;
                gap_cnt_next  = '0;
            end
        endcase
    end

    // State and counter registers; reset discards any partial burst.
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            state    <= IDLE;
            word_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_next;
            word_cnt <= word_cnt_next;
            gap_cnt  <= gap_cnt_next;
        end
    end

    // Host-visible flags are registered from the next state so they are
    // clean and already valid on the first cycle of each state.
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            WR_FIFO_Full  <= 1'b1;
            RD_FIFO_Empty <= 1'b1;
            LastRDData    <= 1'b0;
        end else begin
            WR_FIFO_Full  <= (state_next != SNK_ACTIVE);
            RD_FIFO_Empty <= (state_next != SRC_ACTIVE);
            LastRDData    <= (state_next == SRC_ACTIVE) && (word_cnt_next == LAST_WORD);
        end
    end

    // Each filtered press of the button flips the run request.
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            run_req <= 1'b0;
        end else if (btn_rise && btn_level) begin
            run_req <= ~run_req;
        end
    end

    // Completed bursts, wrapping naturally at 8 bits.
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            burst_count <= 8'd0;
        end else if (burst_done) begin
            burst_count <= burst_count + 8'd1;
        end
    end

    // Sticky protocol error; a fresh start out of IDLE wipes the slate.
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            proto_err <= 1'b0;
        end else if (leaving_idle) begin
            proto_err <= 1'b0;
        end else if (strobe_err) begin
            proto_err <= 1'b1;
        end
    end

endmodule
